// File: rtl/alu_mul_seq_if.sv
// Multiply sequencer bus: requester handshake (start/ready/busy/done/product)
// plus the shared-ALU operand/result path the sequencer drives while busy.
interface alu_mul_seq_if;
    logic        start;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [2:0]  alu_opcode;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        input  alu_result,
        output ready,
        output busy,
        output done,
        output product,
        output alu_opcode,
        output alu_a,
        output alu_b
    );

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        output alu_result,
        input  ready,
        input  busy,
        input  done,
        input  product,
        input  alu_opcode,
        input  alu_a,
        input  alu_b
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add 64x64 (low 64 bits) multiplier driving the shared ALU; done k+1 cycles after start
// (k = multiplier msb index + 1), 1 cycle for a zero multiplier. start only taken while ready; no queueing.
module alu_mul_seq (
    input  logic         clk,
    input  logic         reset,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SUM  = 3'd1;

    state_t      r_state;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [63:0] r_mplier;
    logic [63:0] r_product;
    logic [5:0]  r_count;

    state_t      w_state_nxt;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_mcand_nxt;
    logic [63:0] w_mplier_nxt;
    logic [63:0] w_product_nxt;
    logic [5:0]  w_count_nxt;

    logic        w_accept;
    logic [63:0] w_acc_step;
    logic [63:0] w_mplier_sh;
    logic        w_run_exit;

    // The ALU adds acc+mcand combinationally; only keep the sum when this multiplier bit is set.
    assign w_accept    = (r_state != ST_RUN) && bus.start;
    assign w_acc_step  = r_mplier[0] ? bus.alu_result : r_acc;
    assign w_mplier_sh = r_mplier >> 1;
    assign w_run_exit  = (w_mplier_sh == 64'd0) || (r_count == 6'd63);

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_mcand_nxt    = r_mcand;
        w_mplier_nxt   = r_mplier;
        w_product_nxt  = r_product;
        w_count_nxt    = r_count;

        bus.ready      = 1'b1;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.alu_opcode = OP_LOAD;
        bus.alu_a      = 64'd0;
        bus.alu_b      = 64'd0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                bus.done = (r_state == ST_DONE);
                if (w_accept) begin
                    w_acc_nxt    = 64'd0;
                    w_mcand_nxt  = bus.multiplicand;
                    w_mplier_nxt = bus.multiplier;
                    w_count_nxt  = 6'd0;
                    if (bus.multiplier == 64'd0) begin
                        w_state_nxt   = ST_DONE;
                        w_product_nxt = 64'd0;
                    end else begin
                        w_state_nxt   = ST_RUN;
                    end
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                bus.ready      = 1'b0;
                bus.busy       = 1'b1;
                bus.alu_opcode = OP_SUM;
                bus.alu_a      = r_acc;
                bus.alu_b      = r_mcand;
                w_acc_nxt      = w_acc_step;
                w_mcand_nxt    = r_mcand << 1;
                w_mplier_nxt   = w_mplier_sh;
                w_count_nxt    = r_count + 6'd1;
                // Leave as soon as no multiplier bits remain; count caps the loop at 64 steps.
                if (w_run_exit) begin
                    w_state_nxt   = ST_DONE;
                    w_product_nxt = w_acc_step;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_acc     <= 64'd0;
            r_mcand   <= 64'd0;
            r_mplier  <= 64'd0;
            r_product <= 64'd0;
            r_count   <= 6'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_product <= w_product_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign bus.product = r_product;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that computes the low 64 bits of a 64×64 product by driving the shared 64-bit ALU through a shift-and-add loop. It owns the ALU's opcode and operand inputs while busy and consumes its combinational result in the same cycle. It sits beside the core's execute stage and serves MUL-class instructions that the single-cycle ALU cannot complete alone.

## Interface
Parameters:
- none; widths are fixed at 64 bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request pulse; sampled only while ready=1.
- multiplicand  input  64  operand A, captured when start is accepted.
- multiplier  input  64  operand B, captured when start is accepted.
- ready  output  1  block can accept start; high in IDLE and DONE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  64  low 64 bits of multiplicand×multiplier; held until the next accepted start.
- alu_opcode  output  3  ALU opcode: LOAD=0, SUM=1.
- alu_a  output  64  ALU operand a.
- alu_b  output  64  ALU operand b.
- alu_result  input  64  combinational ALU result for the current alu_opcode/alu_a/alu_b.

## Operation
- State registers: state ∈ {IDLE, RUN, DONE}; acc[63:0], mcand[63:0], mplier[63:0], count[5:0].
- IDLE: ready=1, busy=0, done=0. ALU outputs are parked at opcode=LOAD, a=0, b=0.
- Accept, in IDLE or DONE with start=1:
  - acc←0, mcand←multiplicand, mplier←multiplier, count←0.
  - If multiplier==0: next=DONE, product←0.
  - Otherwise next=RUN.
- RUN, every cycle:
  - Drive opcode=SUM, a=acc, b=mcand.
  - If mplier[0]=1, then acc←alu_result; otherwise acc is unchanged.
  - mcand←mcand<<1 (logical, zero fill, bit 63 discarded); mplier←mplier>>1 (logical); count←count+1.
  - Exit to DONE when (mplier>>1)==0 or count==63.
  - On exit, product←the updated acc value (the same value written to acc).
- DONE: done=1, ready=1, busy=0; ALU outputs parked as in IDLE.
  - start=1: accept (see above); done still pulses this cycle.
  - start=0: next=IDLE.
- start with ready=0 (RUN) is ignored; there is no queueing.
- Arithmetic is modulo 2^64. Signed and unsigned operands produce the same low 64 bits, so the block does not treat signedness specially. ALU status outputs are not used.

## Timing
- Reset (synchronous, wins over every other condition, including mid-RUN):
  - state=IDLE; product=0, acc=0, mcand=0, mplier=0, count=0.
  - done=0, busy=0, ready=1; alu_opcode=0, alu_a=0, alu_b=0.
  - An aborted operation produces no done pulse.
- Let k = index of the highest set bit of multiplier, plus 1 (1..64).
- start accepted at edge E0:
  - RUN occupies cycles E0..E(k-1).
  - done is high in the cycle following edge Ek.
  - Latency start→done = k+1 cycles; zero multiplier = 1 cycle.
- Back-to-back: a start accepted in the DONE cycle enters RUN (or DONE again for a zero multiplier) at the next edge with no IDLE bubble.
- ALU path: alu_result must settle within the same cycle. acc is written only at the clock edge, so there is no combinational loop through registers.
- ready, busy, done and the ALU outputs are decoded from registered state only; they have no combinational path from start.

## Test plan
- multiplicand=3, multiplier=5, start one cycle -> 3 RUN cycles, done pulse on the 4th cycle, product=15, ready high again afterward.
- multiplicand=0x1234, multiplier=0 -> done on the cycle after start, product=0, busy never asserted, ALU stays at LOAD/0/0.
- multiplicand=0xFFFF_FFFF_FFFF_FFFF, multiplier=0xFFFF_FFFF_FFFF_FFFF -> 64 RUN cycles, done 65 cycles after start, product=1; product=0xFFFF_FFFF_FFFF_FFFE for multiplier=2.
- Start 7×9; pulse start again with 2×2 during RUN -> second start ignored, product=63; then start 2×2 in the DONE cycle -> product=4 with no IDLE cycle between.
- Start 0x8000_0000_0000_0001×0x8000_0000_0000_0000; assert reset at RUN cycle 10 -> next cycle state IDLE, product=0, ready=1, no done pulse; a fresh 6×7 afterward yields 42.
- Random operand pairs (≥1000) against a reference model of (a*b) mod 2^64 -> product match, plus done latency equal to k+1.
